// File: rtl/inst_fetch_pkg.sv
// cpu_defs: shared definitions for the instruction-fetch slice
//   fetch_state_t - fetch FSM states (IDLE, REQ, WAIT, DISCARD)
//   RESET_VECTOR  - address the PC register holds after reset
package cpu_defs;
   typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} fetch_state_t;
   localparam logic [31:0] RESET_VECTOR = 32'hbfc00000;
endpackage

// File: rtl/inst_fetch_if_buf.sv
// if_buf: one-entry fetched-instruction register, held until consumed, dropped on flush
//   clk, rst                         - clock, asynchronous active-high reset
//   flush                            - drop the held entry (wins over load and consume)
//   load, ld_pc, ld_inst, ld_adel    - new entry captured this cycle
//   consume                          - downstream accepts the held entry
//   if_valid, if_pc, if_inst, if_adel - held entry
module if_buf #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             load,
   input  logic [WIDTH-1:0] ld_pc,
   input  logic [WIDTH-1:0] ld_inst,
   input  logic             ld_adel,
   input  logic             consume,
   output logic             if_valid,
   output logic [WIDTH-1:0] if_pc,
   output logic [WIDTH-1:0] if_inst,
   output logic             if_adel
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_valid <= 1'b0;
         if_pc    <= '0;
         if_inst  <= '0;
         if_adel  <= 1'b0;
      end else begin
         if_valid <= !flush && (load || (if_valid && !consume));
         if (load && !flush) begin
            if_pc   <= ld_pc;
            if_inst <= ld_inst;
            if_adel <= ld_adel;
         end
      end
   end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: SRAM-like instruction fetch unit with one outstanding request
//   clk, rst                          - clock, asynchronous active-high reset
//   pc, flush                         - current fetch address, redirect pulse
//   pc_en                             - PC register load enable
//   inst_req, inst_addr               - memory request valid / address
//   inst_addr_ok, inst_data_ok, inst_rdata - memory handshakes and read data
//   id_ready                          - decode accepts the held instruction
//   if_valid, if_pc, if_inst, if_adel - fetched-instruction bundle
// Optional: IF_ADEL_CHECK_EN turns misaligned fetch addresses into an
// address-error bundle instead of a memory request.
import cpu_defs::*;

module inst_fetch #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] pc,
   input  logic             flush,
   output logic             pc_en,
   output logic             inst_req,
   output logic [WIDTH-1:0] inst_addr,
   input  logic             inst_addr_ok,
   input  logic             inst_data_ok,
   input  logic [WIDTH-1:0] inst_rdata,
   input  logic             id_ready,
   output logic             if_valid,
   output logic [WIDTH-1:0] if_pc,
   output logic [WIDTH-1:0] if_inst,
   output logic             if_adel
);
   fetch_state_t     state;
   logic [WIDTH-1:0] req_addr, pend_pc;
   logic             killed, cons, adel, fetch_go, data_hit;
   assign inst_req = state == REQ;
   // the request address is frozen on entry to REQ so a redirect cannot move it mid-handshake
   assign inst_addr = inst_req ? req_addr : pc;
   assign pc_en = (inst_req && inst_addr_ok) || flush;
   assign cons = !if_valid || id_ready;
`ifdef IF_ADEL_CHECK_EN
   assign adel = state == IDLE && cons && !flush && pc[1:0] != 2'b00;
`else
   assign adel = 1'b0;
`endif
   assign fetch_go = state == IDLE && cons && !flush && !adel;
   assign data_hit = state == WAIT && inst_data_ok && !flush;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         req_addr <= WIDTH'(RESET_VECTOR);
         pend_pc  <= '0;
         killed   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (fetch_go) begin
               state    <= REQ;
               req_addr <= pc;
            end
            // a flush seen before the handshake turns the accepted request into one to discard
            REQ: if (inst_addr_ok) begin
               state   <= (killed || flush) ? DISCARD : WAIT;
               pend_pc <= req_addr;
               killed  <= 1'b0;
            end else if (flush) begin
               killed <= 1'b1;
            end
            // chaining straight into the next request needs decode to be taking instructions now,
            // otherwise the returning data could land on an unconsumed entry
            WAIT: if (flush) begin
               state <= inst_data_ok ? IDLE : DISCARD;
            end else if (inst_data_ok) begin
               state    <= id_ready ? REQ : IDLE;
               req_addr <= pc;
            end
            DISCARD: if (inst_data_ok) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
   if_buf #(.WIDTH(WIDTH)) u_buf (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .load     (data_hit || adel),
      .ld_pc    (adel ? pc : pend_pc),
      .ld_inst  (adel ? '0 : inst_rdata),
      .ld_adel  (adel),
      .consume  (id_ready),
      .if_valid (if_valid),
      .if_pc    (if_pc),
      .if_inst  (if_inst),
      .if_adel  (if_adel)
   );
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized scoreboard bench for inst_fetch, acting as PC register, memory and decode
module tb_inst_fetch;
   import cpu_defs::*;
   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] pc = 32'h0, inst_addr, inst_rdata = 32'h0, if_pc, if_inst;
   logic        flush = 1'b0, pc_en, inst_req, inst_addr_ok = 1'b0, inst_data_ok = 1'b0;
   logic        id_ready = 1'b0, if_valid, if_adel;

   inst_fetch #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .pc(pc), .flush(flush), .pc_en(pc_en),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .id_ready(id_ready),
      .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_adel(if_adel)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
      int          due;
   } exp_t;
   exp_t sb[$];

   int errors = 0, checks = 0, cyc = 0, n_pop = 0;
   int aok_pct = 50, dly_max = 2, dly_fix = -1, flush_pct = 0;
   bit rdy_rand = 1'b1, rdy_val = 1'b1, force_flush = 1'b0;
   logic [31:0] flush_tgt = 32'h0;
   // model of the environment: PC register, one-deep memory, request tracking
   logic [31:0] m_pc = RESET_VECTOR, busy_addr = 32'h0, req_addr_exp = 32'h0;
   bit busy = 1'b0, busy_kill = 1'b0, req_seen = 1'b0, req_kill = 1'b0;
   int wait_left = 0, hs_cnt = 0, pcen_seen = 0;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a == 32'hbfc00000 ? 32'h24080001 : (a * 32'h9e3779b1) ^ 32'h0badf00d;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; flush = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
      id_ready = 1'b0; inst_rdata = 32'h0; force_flush = 1'b0;
      m_pc = RESET_VECTOR; pc = m_pc; busy = 1'b0; req_seen = 1'b0;
      sb.delete();
      #2;
      check("rst_if_valid", if_valid, 0);
      check("rst_if_pc", if_pc, 0);
      check("rst_if_inst", if_inst, 0);
      check("rst_if_adel", if_adel, 0);
      check("rst_inst_req", inst_req, 0);
      check("rst_pc_en", pc_en, 0);
   endtask

   // one clock cycle: drive inputs at negedge, check request side, then advance the model
   task automatic step();
      bit hs;
      @(negedge clk);
      rst = 1'b0;
      cyc++;
      if (!force_flush && $urandom_range(99) < flush_pct) begin
         force_flush = 1'b1;
         flush_tgt = $urandom & ~32'h3;
      end
      flush = force_flush;
      force_flush = 1'b0;
      pc = m_pc;
      inst_addr_ok = inst_req && ($urandom_range(99) < aok_pct);
      inst_data_ok = busy && wait_left == 0;
      inst_rdata = inst_data_ok ? (busy_kill ? 32'hdeadbeef : mem(busy_addr)) : $urandom;
      id_ready = rdy_rand ? ((inst_req || busy) ? 1'b1 : 1'($urandom_range(1))) : rdy_val;
      #2;
      hs = inst_req && inst_addr_ok;
      check("pc_en", pc_en, hs || flush);
      if (pc_en) pcen_seen++;
      if (inst_req && !req_seen) begin
         check("one_outstanding", busy, 0);
         check("req_addr", inst_addr, m_pc);
         req_seen = 1'b1; req_kill = 1'b0; req_addr_exp = m_pc;
      end else if (inst_req) begin
         check("req_addr_hold", inst_addr, req_addr_exp);
      end else if (req_seen) begin
         check("req_hold", inst_req, 1);
         req_seen = 1'b0;
      end
      if (flush && req_seen) req_kill = 1'b1;
      if (flush && busy) busy_kill = 1'b1;
      if (inst_data_ok) begin
         if (!busy_kill) sb.push_back('{busy_addr, mem(busy_addr), 1'b0, cyc + 1});
         busy = 1'b0;
      end else if (busy) begin
         wait_left--;
      end
      if (hs) begin
         busy = 1'b1; busy_addr = req_addr_exp; busy_kill = req_kill; req_seen = 1'b0; hs_cnt++;
         wait_left = dly_fix >= 0 ? dly_fix : int'($urandom_range(dly_max));
      end
      m_pc = flush ? flush_tgt : hs ? m_pc + 32'd4 : m_pc;
   endtask

   // monitor: compares each bundle as it leaves the buffer
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            if (if_valid) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_valid: if_pc=%h if_inst=%h with nothing expected", if_pc, if_inst);
               end else if (id_ready || flush) begin
                  e = sb.pop_front();
                  n_pop++;
                  check("if_pc", if_pc, e.pc);
                  check("if_inst", if_inst, e.inst);
                  check("if_adel", if_adel, e.adel);
               end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
               checks++;
               errors++;
               $display("FAIL late_valid: if_valid=0 required 1 for pc %h", sb[0].pc);
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not reach the summary");
      $fatal(1, "timeout");
   end

   initial begin
      bit got_req;
      int cnt0;
      // basic fetch: handshake immediately, data next cycle
      do_reset();
      aok_pct = 100; dly_fix = 0; rdy_rand = 1'b0; rdy_val = 1'b1; pcen_seen = 0;
      step();
      step();
      aok_pct = 0;
      step();
      step();
      check("t1_if_valid", if_valid, 1);
      check("t1_if_pc", if_pc, 32'hbfc00000);
      check("t1_if_inst", if_inst, 32'h24080001);
      check("t1_pc_en_pulses", pcen_seen, 1);
      // delayed addr_ok: request held for four cycles
      pcen_seen = 0;
      check("t2_req", inst_req, 1);
      repeat (2) begin
         step();
         check("t2_req", inst_req, 1);
         check("t2_addr", inst_addr, 32'hbfc00004);
      end
      aok_pct = 100; rdy_val = 1'b0;
      step();
      check("t2_addr", inst_addr, 32'hbfc00004);
      aok_pct = 0;
      check("t2_pc_en_pulses", pcen_seen, 1);
      // decode stalls: bundle held, no new request
      step();
      repeat (5) begin
         step();
         check("t3_valid", if_valid, 1);
         check("t3_pc", if_pc, 32'hbfc00004);
         check("t3_inst", if_inst, mem(32'hbfc00004));
         check("t3_no_req", inst_req, 0);
      end
      rdy_val = 1'b1;
      step();
      step();
      check("t3_req_after_ready", inst_req, 1);
      check("t3_next_addr", inst_addr, 32'hbfc00008);
      // flush while waiting for data; the stale word must never surface
      aok_pct = 100; dly_fix = 2;
      step();
      dly_fix = 0;
      force_flush = 1'b1; flush_tgt = 32'h80000100;
      step();
      got_req = 1'b0;
      for (int i = 0; i < 6 && !got_req; i++) begin
         step();
         check("t4_no_deadbeef", 32'(if_valid && if_inst == 32'hdeadbeef), 0);
         if (inst_req) begin
            got_req = 1'b1;
            check("t4_redirect_addr", inst_addr, 32'h80000100);
         end
      end
      check("t4_redirect_req", got_req, 1);
      // flush together with data_ok and id_ready
      force_flush = 1'b1; flush_tgt = 32'h80000200;
      step();
      step();
      check("t5_if_valid", if_valid, 0);
      check("t5_idle", inst_req, 0);
      // throughput with a zero-wait memory
      step();
      step();
      cnt0 = hs_cnt;
      repeat (20) step();
      check("t6_throughput", hs_cnt - cnt0, 10);
      // randomized traffic with flushes and occasional resets
      aok_pct = 50; dly_fix = -1; dly_max = 2; rdy_rand = 1'b1; flush_pct = 8;
      cnt0 = n_pop;
      for (int i = 0; i < 1500; i++) begin
         if (i % 500 == 499) do_reset();
         step();
      end
      check("random_delivered", 32'(n_pop - cnt0 > 100), 1);
      flush_pct = 0;
`ifdef IF_ADEL_CHECK_EN
      do_reset();
      rdy_rand = 1'b0; rdy_val = 1'b0; aok_pct = 100;
      m_pc = 32'hbfc00002;
      step();
      check("adel_no_req", inst_req, 0);
      sb.push_back('{32'hbfc00002, 32'h0, 1'b1, cyc + 1});
      step();
      check("adel_valid", if_valid, 1);
      check("adel_flag", if_adel, 1);
      check("adel_pc", if_pc, 32'hbfc00002);
      check("adel_inst", if_inst, 0);
      repeat (3) begin
         step();
         check("adel_hold_no_req", inst_req, 0);
      end
`endif
      do_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter WIDTH, default 32, address/data width.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port pc  input  WIDTH  current fetch address from the PC register.
REQ-005 SHALL have port flush  input  1  redirect pulse (eret/exc/mispredict/jump) this cycle.
REQ-006 SHALL have port pc_en  output  1  PC register load enable.
REQ-007 SHALL have port inst_req  output  1  SRAM-like request valid.
REQ-008 SHALL have port inst_addr  output  WIDTH  request address.
REQ-009 SHALL have port inst_addr_ok  input  1  request accepted.
REQ-010 SHALL have port inst_data_ok  input  1  read data valid.
REQ-011 SHALL have port inst_rdata  input  WIDTH  read data.
REQ-012 SHALL have port id_ready  input  1  decode accepts the fetched instruction.
REQ-013 SHALL have ports if_valid (1), if_pc (WIDTH), if_inst (WIDTH), if_adel (1), all outputs, forming the fetched-instruction bundle.

Function
REQ-014 SHALL implement states IDLE, REQ, WAIT, DISCARD; at most one outstanding memory request.
REQ-015 IDLE->REQ when no valid instruction is held or id_ready=1 in that cycle, and flush=0.
REQ-016 REQ: inst_req=1, inst_addr=pc; both held stable until inst_addr_ok; on handshake, latch pc into pend_pc and go to WAIT.
REQ-017 flush during REQ before addr_ok: inst_req SHALL stay asserted; on handshake go to DISCARD, not WAIT.
REQ-018 WAIT: on inst_data_ok with flush=0, register if_inst=inst_rdata, if_pc=pend_pc, if_valid=1 next cycle, go to IDLE (or REQ if the consume condition of REQ-015 holds).
REQ-019 WAIT with flush=1 (including same cycle as data_ok): go to DISCARD if data_ok=0, IDLE if data_ok=1; data never presented.
REQ-020 DISCARD: drop the next inst_data_ok and go to IDLE; inst_req=0.
REQ-021 pc_en = (inst_req & inst_addr_ok) | flush.
REQ-022 if_valid SHALL hold with if_pc/if_inst stable until id_ready=1; then clear unless a new fetch completes that same cycle.
REQ-023 flush SHALL clear if_valid next cycle, overriding id_ready and data_ok.
REQ-024 Minimum latency: addr_ok in cycle N, data_ok in N+1 -> if_valid in N+2; back-to-back fetch issues with id_ready=1 sustain one instruction per 2 cycles.

Reset
REQ-025 On rst: state=IDLE, if_valid=0, if_pc=0, if_inst=0, if_adel=0, inst_req=0, pc_en=0 (combinational outputs follow state), pend_pc=0.
REQ-026 rst mid-transaction SHALL abandon the request; the memory side is reset by the same rst.

Configuration
REQ-027 Macro IF_ADEL_CHECK_EN defined: pc[1:0]!=0 in IDLE issues no request; next cycle if_valid=1, if_adel=1, if_inst=0, if_pc=pc; pc_en=0 until flush.
REQ-028 IF_ADEL_CHECK_EN undefined: all addresses issued unchecked; if_adel tied 0.

Structure
REQ-029 Package cpu_defs SHALL hold the fetch-state enum and the reset vector constant 32'hbfc00000.
REQ-030 Output bundle SHALL be a sub-module if_buf (1-entry valid/pc/inst/adel register with hold/clear/flush).

Verification
REQ-031 rst release, pc=bfc00000, addr_ok same cycle, data_ok next cycle with rdata=24080001, id_ready=1 -> if_valid with if_pc=bfc00000, if_inst=24080001 two cycles after handshake; pc_en one pulse.
REQ-032 addr_ok delayed 3 cycles -> inst_req/inst_addr stable for all 4 cycles; pc_en only in the handshake cycle.
REQ-033 id_ready=0 for 5 cycles after if_valid -> bundle stable; no new inst_req until id_ready=1.
REQ-034 flush in WAIT, data_ok 2 cycles later with rdata=DEADBEEF -> DEADBEEF never appears on if_inst; next request uses the redirected pc.
REQ-035 flush same cycle as data_ok and id_ready -> if_valid=0 next cycle; state IDLE.
REQ-036 IF_ADEL_CHECK_EN, pc=bfc00002 -> no inst_req; if_valid=1, if_adel=1, if_pc=bfc00002 next cycle.
